// File: rtl/rz_deframe.sv
// rz_deframe: decodes an RZ serial line into 24-bit words. Each high pulse
// carries one bit (its width selects 0 or 1). A long low gap ends a frame.
// Decoded words are offered on a valid/ready port that holds one word.
//
// state | meaning
// SYNC  | hunting for a full low gap; pulses are ignored
// IDLE  | gap seen, waiting for the first rise of a frame
// HIGH  | measuring a high pulse
// LOW   | measuring the low time after a pulse
module rz_deframe #(
  parameter int MIN_HIGH   = 10,
  parameter int BIT_THRESH = 58,
  parameter int MAX_HIGH   = 180,
  parameter int RESET_CYC  = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_end,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] word_cnt
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYC + 1);
  localparam logic [HW-1:0] MIN_H = HW'(MIN_HIGH);
  localparam logic [HW-1:0] THR_H = HW'(BIT_THRESH);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HIGH);
  localparam logic [LW-1:0] RST_L = LW'(RESET_CYC);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            din_s, din_prev, rise, fall;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d, lcnt_inc;
  logic [23:0]     shreg_q;
  logic [4:0]      bit_cnt_q;
  logic            ev_glitch, ev_long, ev_gap, ev_bit, bit_val;
  logic            word_done, xfer, load, drop, partial, err_any;
  logic [1:0]      err_code_d;
  logic [23:0]     word_next;

  assign din_s    = sync_q[1];
  assign rise     = ~din_prev & din_s;
  assign fall     = din_prev & ~din_s;
  assign lcnt_inc = (lcnt_q == RST_L) ? lcnt_q : lcnt_q + 1'b1;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      din_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], din};
      din_prev <= sync_q[1];
    end
  end

  // State register together with the high/low timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Next state, timer updates and the per-cycle line events
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    ev_glitch = 1'b0;
    ev_long   = 1'b0;
    ev_gap    = 1'b0;
    ev_bit    = 1'b0;
    bit_val   = 1'b0;
    case (state_q)
      SYNC: begin
        if (din_s) begin
          lcnt_d = '0;
        end else if (lcnt_inc == RST_L) begin
          lcnt_d  = '0;
          state_d = IDLE;
        end else begin
          lcnt_d = lcnt_inc;
        end
      end
      IDLE: begin
        if (rise) begin
          hcnt_d  = HW'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (din_s) begin
          if (hcnt_q == MAX_H) begin
            ev_long = 1'b1;
            hcnt_d  = '0;
            lcnt_d  = '0;
            state_d = SYNC;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (fall) begin
          if (hcnt_q < MIN_H) begin
            ev_glitch = 1'b1;
          end else begin
            ev_bit  = 1'b1;
            bit_val = (hcnt_q > THR_H);
          end
          lcnt_d  = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          hcnt_d  = HW'(1);
          state_d = HIGH;
        end else if (lcnt_inc == RST_L) begin
          ev_gap  = 1'b1;
          lcnt_d  = '0;
          state_d = IDLE;
        end else begin
          lcnt_d = lcnt_inc;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Word completion, handshake decisions and error cause priority
  always_comb begin
    word_done  = ev_bit && (bit_cnt_q == 5'd23);
    word_next  = {shreg_q[22:0], bit_val};
    xfer       = m_valid && m_ready;
    load       = word_done && (!m_valid || xfer);
    drop       = word_done && m_valid && !m_ready;
    partial    = ev_gap && (bit_cnt_q != 5'd0);
    err_any    = ev_glitch || ev_long || partial || drop;
    err_code_d = 2'd3;
    if (ev_glitch)    err_code_d = 2'd0;
    else if (ev_long) err_code_d = 2'd1;
    else if (partial) err_code_d = 2'd2;
  end

  // Bit shifter and bit counter; a long pulse or a gap throws the partial word away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (ev_long || ev_gap) begin
      bit_cnt_q <= '0;
    end else if (ev_bit) begin
      shreg_q   <= word_next;
      bit_cnt_q <= (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;
    end
  end

  // Registered outputs: holding register, status pulses and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_end <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      word_cnt  <= '0;
    end else begin
      frame_end <= ev_gap;
      err       <= err_any;
      err_code  <= err_any ? err_code_d : 2'd0;
      if (load) begin
        m_data  <= word_next;
        m_valid <= 1'b1;
      end else if (xfer) begin
        m_valid <= 1'b0;
      end
      if (frame_end) begin
        word_cnt <= '0;
      end else if (load && (word_cnt != 16'hFFFF)) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rz_deframe.sv
// Bench for rz_deframe: a run-length model of the line predicts every output
// each cycle; scenario checks pin the model with hand-known values.
module tb_rz_deframe;
  localparam int MIN_HIGH   = 10;
  localparam int BIT_THRESH = 58;
  localparam int MAX_HIGH   = 180;
  localparam int RESET_CYC  = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        m_ready = 1'b1;
  logic [23:0] m_data;
  logic        m_valid, frame_end, err;
  logic [1:0]  err_code;
  logic [15:0] word_cnt;

  rz_deframe #(
    .MIN_HIGH(MIN_HIGH), .BIT_THRESH(BIT_THRESH),
    .MAX_HIGH(MAX_HIGH), .RESET_CYC(RESET_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_end(frame_end), .err(err), .err_code(err_code), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (line run lengths) ----------------
  logic        ms1, ms2, mprev;
  int          mode;      // 0 hunting gap, 1 waiting first rise, 2 in high, 3 in low
  int          hi_run, lo_run, nbits;
  logic [23:0] acc;
  logic        e_valid, e_fe, e_err;
  logic [23:0] e_data;
  logic [1:0]  e_code;
  int          e_wcnt;

  task automatic model_reset();
    ms1 = 0; ms2 = 0; mprev = 0;
    mode = 0; hi_run = 0; lo_run = 0; nbits = 0; acc = '0;
    e_valid = 0; e_data = '0; e_fe = 0; e_err = 0; e_code = 0; e_wcnt = 0;
  endtask

  task automatic model_step();
    logic s, p, rdy, glitch, long_h, gap, done, partial, load, drop, xfer, any;
    logic [1:0] code;
    s = ms2; p = mprev; rdy = m_ready;
    mprev = ms2; ms2 = ms1; ms1 = din;
    glitch = 0; long_h = 0; gap = 0; done = 0; partial = 0;
    case (mode)
      0: begin
        if (s) lo_run = 0;
        else begin
          lo_run++;
          if (lo_run == RESET_CYC) mode = 1;
        end
      end
      1: if (!p && s) begin mode = 2; hi_run = 1; end
      2: begin
        if (s) begin
          hi_run++;
          if (hi_run > MAX_HIGH) begin long_h = 1; nbits = 0; mode = 0; lo_run = 0; end
        end else begin
          if (hi_run < MIN_HIGH) glitch = 1;
          else begin
            acc = {acc[22:0], (hi_run > BIT_THRESH)};
            nbits++;
            if (nbits == 24) begin done = 1; nbits = 0; end
          end
          mode = 3; lo_run = 1;
        end
      end
      default: begin
        if (s) begin mode = 2; hi_run = 1; end
        else begin
          lo_run++;
          if (lo_run == RESET_CYC + 1) begin
            gap = 1; partial = (nbits != 0); nbits = 0; mode = 1;
          end
        end
      end
    endcase
    xfer = e_valid && rdy;
    load = done && (!e_valid || xfer);
    drop = done && !load;
    any  = glitch || long_h || partial || drop;
    code = glitch ? 2'd0 : long_h ? 2'd1 : partial ? 2'd2 : 2'd3;
    if (e_fe) e_wcnt = 0;
    if (load) begin
      e_valid = 1; e_data = acc;
      if (e_wcnt < 65535) e_wcnt++;
    end else if (xfer) e_valid = 0;
    e_fe = gap; e_err = any; e_code = any ? code : 2'd0;
  endtask

  // ---------------- per-cycle compare and DUT observation ----------------
  int          fe_seen = 0, fe_err2 = 0;
  int          err_seen[4];
  logic [23:0] got[$];
  logic        seen_v = 0;
  logic [23:0] seen_d = '0;

  initial begin
    logic [44:0] dv, ev;
    for (int i = 0; i < 4; i++) err_seen[i] = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        if (seen_v && m_ready) got.push_back(seen_d);
        model_step();
      end
      @(negedge clk);
      if (!rst_n) model_reset();
      dv = {m_valid, (m_valid ? m_data : 24'h0), frame_end, err, (err ? err_code : 2'b00), word_cnt};
      ev = {e_valid, (e_valid ? e_data : 24'h0), e_fe, e_err, e_code, 16'(e_wcnt)};
      check("outputs_vs_model", 64'(dv), 64'(ev));
      seen_v = m_valid; seen_d = m_data;
      if (frame_end) fe_seen++;
      if (err) err_seen[err_code]++;
      if (frame_end && err && err_code == 2'd2) fe_err2++;
    end
  end

  // ---------------- stimulus ----------------
  logic rand_ready = 0;

  function automatic logic [23:0] word_at(input int idx);
    if (idx >= 0 && idx < got.size()) return got[idx];
    return 24'h0;
  endfunction

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // timing 0: nominal 80/45 and 30/95; 1: random legal; 2: threshold edges 59/58
  task automatic send_bit(input logic b, input int tmode, input logic glitch);
    int hi, lo;
    if (tmode == 0) begin
      hi = b ? 80 : 30; lo = b ? 45 : 95;
    end else if (tmode == 1) begin
      hi = b ? int'($urandom_range(BIT_THRESH + 1, MAX_HIGH)) : int'($urandom_range(MIN_HIGH, BIT_THRESH));
      lo = int'($urandom_range(15, 40));
    end else begin
      hi = b ? BIT_THRESH + 1 : BIT_THRESH; lo = 50;
    end
    hold(1'b1, hi);
    if (glitch) begin
      hold(1'b0, 40); hold(1'b1, 5);
    end
    hold(1'b0, lo);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n, input int tmode, input int glitch_at);
    for (int i = 0; i < n; i++) send_bit(w[23-i], tmode, (i == glitch_at));
  endtask

  initial begin
    logic [23:0] w[3];
    logic [23:0] wa, wb;
    int n0, fe0, e0, e1, e2, e3, f2;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: single nominal word
    hold(1'b0, RESET_CYC + 10);
    send_bits(24'hA5C33C, 24, 0, -1);
    hold(1'b0, 200);
    check("s1_count", 64'(got.size()), 64'd1);
    check("s1_word", 64'(word_at(0)), 64'hA5C33C);
    check("s1_wcnt", 64'(word_cnt), 64'd1);
    fe0 = fe_seen;
    hold(1'b0, RESET_CYC + 10);
    check("s1_frame_end", 64'(fe_seen - fe0), 64'd1);
    check("s1_wcnt_clr", 64'(word_cnt), 64'd0);

    // 2: three back-to-back words then gap
    n0 = got.size();
    for (int i = 0; i < 3; i++) begin
      w[i] = 24'($urandom);
      send_bits(w[i], 24, 1, -1);
    end
    hold(1'b0, 50);
    check("s2_wcnt3", 64'(word_cnt), 64'd3);
    for (int i = 0; i < 3; i++) check("s2_order", 64'(word_at(n0 + i)), 64'(w[i]));
    fe0 = fe_seen;
    hold(1'b0, RESET_CYC + 10);
    check("s2_frame_end", 64'(fe_seen - fe0), 64'd1);
    check("s2_wcnt0", 64'(word_cnt), 64'd0);

    // 3: stalled consumer across two words
    n0 = got.size(); e3 = err_seen[3];
    wa = 24'($urandom); wb = ~wa;
    m_ready = 1'b0;
    send_bits(wa, 24, 0, -1);
    send_bits(wb, 24, 0, -1);
    hold(1'b0, 100);
    check("s3_held_valid", 64'(m_valid), 64'd1);
    check("s3_held_data", 64'(m_data), 64'(wa));
    check("s3_overflow", 64'(err_seen[3] - e3), 64'd1);
    check("s3_wcnt", 64'(word_cnt), 64'd1);
    m_ready = 1'b1;
    hold(1'b0, 10);
    check("s3_drained", 64'(got.size() - n0), 64'd1);
    check("s3_drained_word", 64'(word_at(n0)), 64'(wa));
    check("s3_valid_clr", 64'(m_valid), 64'd0);

    // 4: glitch inside a word, then an over-long pulse
    e0 = err_seen[0]; e1 = err_seen[1];
    wa = 24'($urandom);
    send_bits(wa, 24, 0, 5);
    hold(1'b0, 50);
    check("s4_glitch_err", 64'(err_seen[0] - e0), 64'd1);
    check("s4_glitch_word", 64'(word_at(got.size() - 1)), 64'(wa));
    n0 = got.size();
    hold(1'b1, 200);
    hold(1'b0, 45);
    send_bits(24'($urandom), 5, 0, -1);
    hold(1'b0, 100);
    check("s4_long_err", 64'(err_seen[1] - e1), 64'd1);
    check("s4_no_word", 64'(got.size() - n0), 64'd0);
    check("s4_no_valid", 64'(m_valid), 64'd0);
    fe0 = fe_seen;
    hold(1'b0, RESET_CYC + 10);
    check("s4_sync_no_fe", 64'(fe_seen - fe0), 64'd0);
    wb = 24'($urandom);
    send_bits(wb, 24, 1, -1);
    hold(1'b0, 50);
    check("s4_resync_word", 64'(word_at(got.size() - 1)), 64'(wb));

    // 5: partial word at a gap
    n0 = got.size(); e2 = err_seen[2]; f2 = fe_err2; fe0 = fe_seen;
    send_bits(24'($urandom), 10, 0, -1);
    hold(1'b0, RESET_CYC + 10);
    check("s5_partial_err", 64'(err_seen[2] - e2), 64'd1);
    check("s5_with_fe", 64'(fe_err2 - f2), 64'd1);
    check("s5_fe", 64'(fe_seen - fe0), 64'd1);
    check("s5_no_word", 64'(got.size() - n0), 64'd0);

    // 6: threshold high times 58 -> 0, 59 -> 1
    send_bits(24'hC3A596, 24, 2, -1);
    hold(1'b0, 50);
    check("s6_thresh_word", 64'(word_at(got.size() - 1)), 64'hC3A596);

    // 7: random words with a random consumer
    n0 = got.size();
    rand_ready = 1'b1;
    wa = 24'($urandom); wb = 24'($urandom);
    send_bits(wa, 24, 1, -1);
    send_bits(wb, 24, 1, -1);
    rand_ready = 1'b0; m_ready = 1'b1;
    hold(1'b0, 50);
    check("s7_word_a", 64'(word_at(n0)), 64'(wa));
    check("s7_word_b", 64'(word_at(n0 + 1)), 64'(wb));

    // 8: reset mid-word with a held word
    n0 = got.size();
    m_ready = 1'b0;
    send_bits(24'($urandom), 24, 0, -1);
    hold(1'b0, 20);
    check("s8_pre_valid", 64'(m_valid), 64'd1);
    send_bits(24'($urandom), 12, 0, -1);
    din = 1'b1;
    hold(1'b1, 20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("s8_rst_outputs", 64'({m_valid, m_data, frame_end, err, err_code, word_cnt}), 64'd0);
    din = 1'b0;
    @(negedge clk);
    hold(1'b0, 3);
    rst_n = 1'b1;
    m_ready = 1'b1;
    send_bits(24'($urandom), 24, 0, -1);
    hold(1'b0, 50);
    check("s8_no_decode", 64'(got.size() - n0), 64'd0);
    check("s8_no_valid", 64'(m_valid), 64'd0);
    hold(1'b0, RESET_CYC + 10);
    wa = 24'($urandom);
    send_bits(wa, 24, 0, -1);
    hold(1'b0, 50);
    check("s8_after_gap", 64'(word_at(got.size() - 1)), 64'(wa));
    check("s8_wcnt", 64'(word_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
